// File: rtl/des_decrypt_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | des_decrypt_iter : iterative DES decryption, one Feistel round per clock |
// | Optional CBC chaining with macro DES_DEC_CBC_EN.  Rev 1.0                |
// +--------------------------------------------------------------------------+

module sboxes (
  input  logic [47:0] din,
  output logic [31:0] dout
);
  // Entry (row*16+col) of each box sits at nibble position 63-index.
  localparam logic [255:0] c_sbox [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    logic [5:0] w_six;
    logic [5:0] w_idx;
    assign w_six = din[47-6*g -: 6];
    assign w_idx = {w_six[5], w_six[0], w_six[4:1]};
    assign dout[31-4*g -: 4] = c_sbox[g][{~w_idx, 2'b00} +: 4];
  end
endmodule

module des_decrypt_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef DES_DEC_CBC_EN
  input  logic [63:0] iv,
  input  logic        iv_load,
`endif
  output logic [63:0] out_data
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Tables list DES bit numbers (1 = MSB); unused tail entries are zero.
  localparam int c_ip [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int c_fp [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int c_e [64] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
    12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
    28,29,30,31,32,1, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
  localparam int c_p [64] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25, 0,0,0,0,0,0,0,0,
    0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
  localparam int c_pc1 [64] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4, 0,0,0,0,0,0,0,0};
  localparam int c_pc2 [64] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
    16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53,
    46,42,50,36,29,32, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};

  // Source is right-aligned in n_in bits; result is right-aligned in n_out bits.
  function automatic logic [63:0] perm(input logic [63:0] src, input int n_in,
                                       input int n_out, input int tbl [64]);
    logic [63:0] res;
    res = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < n_out) res[6'(n_out - 1 - i)] = src[6'(n_in - tbl[i])];
    end
    return res;
  endfunction

  logic [1:0]  r_state, w_state_nxt;
  logic [31:0] r_l, r_r;
  logic [27:0] r_c, r_d;
  logic [3:0]  r_cnt;
  logic [63:0] r_out;
`ifdef DES_DEC_CBC_EN
  logic [63:0] r_chain, r_ctext;
`endif

  logic [63:0] w_ip, w_plain;
  logic [55:0] w_pc1;
  logic [27:0] w_c_rot, w_d_rot;
  logic [47:0] w_key, w_e;
  logic [31:0] w_sbo, w_f, w_new_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_ROUND;
      S_ROUND: if (r_cnt == 4'd15) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Decryption walks the key schedule backwards: right rotations 0,1,2..2,1,2..2,1.
  always_comb begin
    w_c_rot = r_c;
    w_d_rot = r_d;
    if (r_cnt == 4'd1 || r_cnt == 4'd8 || r_cnt == 4'd15) begin
      w_c_rot = {r_c[0], r_c[27:1]};
      w_d_rot = {r_d[0], r_d[27:1]};
    end else if (r_cnt != 4'd0) begin
      w_c_rot = {r_c[1:0], r_c[27:2]};
      w_d_rot = {r_d[1:0], r_d[27:2]};
    end
  end

  assign w_ip    = perm(in_data, 64, 64, c_ip);
  assign w_pc1   = 56'(perm(in_key, 64, 56, c_pc1));
  assign w_key   = 48'(perm({8'd0, w_c_rot, w_d_rot}, 56, 48, c_pc2));
  assign w_e     = 48'(perm({32'd0, r_r}, 32, 48, c_e));
  assign w_f     = 32'(perm({32'd0, w_sbo}, 32, 32, c_p));
  assign w_new_r = r_l ^ w_f;

  sboxes u_sboxes (
    .din  (w_e ^ w_key),
    .dout (w_sbo)
  );

`ifdef DES_DEC_CBC_EN
  assign w_plain = perm({w_new_r, r_r}, 64, 64, c_fp) ^ r_chain;
`else
  assign w_plain = perm({w_new_r, r_r}, 64, 64, c_fp);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l   <= '0;
      r_r   <= '0;
      r_c   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_out <= '0;
`ifdef DES_DEC_CBC_EN
      r_chain <= '0;
      r_ctext <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef DES_DEC_CBC_EN
          if (iv_load) r_chain <= iv;
`endif
          if (in_valid) begin
            r_l   <= w_ip[63:32];
            r_r   <= w_ip[31:0];
            r_c   <= w_pc1[55:28];
            r_d   <= w_pc1[27:0];
            r_cnt <= 4'd0;
`ifdef DES_DEC_CBC_EN
            r_ctext <= in_data;
`endif
          end
        end
        S_ROUND: begin
          r_c <= w_c_rot;
          r_d <= w_d_rot;
          r_l <= r_r;
          r_r <= w_new_r;
          if (r_cnt == 4'd15) r_out <= w_plain;
          else                r_cnt <= r_cnt + 4'd1;
        end
        S_DONE: begin
`ifdef DES_DEC_CBC_EN
          if (out_ready) r_chain <= r_ctext;
`endif
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_out;
endmodule
`default_nettype wire

// File: tb/tb_des_decrypt_iter.sv
`default_nettype none
// Self-checking bench for des_decrypt_iter: reference DES model with a
// precomputed forward key schedule applied in reverse.
module tb_des_decrypt_iter;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] in_data = '0, in_key = '0;
  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [63:0] m_ct = '0;
`ifdef DES_DEC_CBC_EN
  logic [63:0] iv = '0;
  logic        iv_load = 1'b0;
  logic [63:0] m_chain = '0;
`endif
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  des_decrypt_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef DES_DEC_CBC_EN
    .iv(iv), .iv_load(iv_load),
`endif
    .out_data(out_data)
  );

  int t_ip [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int t_fp [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int t_e [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int t_p [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int t_pc1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int t_pc2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  logic [255:0] t_sb [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic int tb_tbl(input int which, input int i);
    case (which)
      0: return t_ip[i];
      1: return t_fp[i];
      2: return t_e[i];
      3: return t_p[i];
      4: return t_pc1[i];
      default: return t_pc2[i];
    endcase
  endfunction

  function automatic logic [63:0] pm(input logic [63:0] x, input int nin, input int nout, input int which);
    logic [63:0] y = '0;
    for (int i = 0; i < nout; i++) y[nout-1-i] = x[nin - tb_tbl(which, i)];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e = pm({32'd0, r}, 32, 48, 2) ^ k;
    logic [63:0] s = '0;
    for (int b = 0; b < 8; b++) begin
      int six = int'((e >> (42 - 6*b)) & 48'h3F);
      int idx = ((six >> 5) * 2 + (six & 1)) * 16 + ((six >> 1) & 15);
      s = (s << 4) | 64'((t_sb[b] >> (4 * (63 - idx))) & 256'hF);
    end
    return pm(s, 32, 32, 3)[31:0];
  endfunction

  // Standard schedule: left shifts 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; apply K16..K1.
  function automatic logic [63:0] des_dec(input logic [63:0] ct, input logic [63:0] key);
    logic [63:0] cd = pm(key, 64, 56, 4);
    logic [27:0] c = cd[55:28], d = cd[27:0];
    logic [47:0] ks [16];
    logic [63:0] x = pm(ct, 64, 64, 0);
    logic [31:0] l = x[63:32], r = x[31:0], t;
    for (int i = 0; i < 16; i++) begin
      int s = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
      c = (c << s) | (c >> (28 - s));
      d = (d << s) | (d >> (28 - s));
      ks[i] = pm({8'd0, c, d}, 56, 48, 5)[47:0];
    end
    for (int i = 15; i >= 0; i--) begin
      t = r;
      r = l ^ feistel(r, ks[i]);
      l = t;
    end
    return pm({r, l}, 64, 64, 1);
  endfunction

  function automatic logic [63:0] cm();
`ifdef DES_DEC_CBC_EN
    return m_chain;
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [63:0] ct, input logic [63:0] key, output logic ok);
    int n = 0;
    in_data = ct; in_key = key; in_valid = 1'b1;
    while (!in_ready && n < 100) begin step(); n++; end
    ok = in_ready;
    if (ok) m_ct = ct;
    step();
    in_valid = 1'b0; in_data = rnd64(); in_key = rnd64();
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin step(); cyc++; end
  endtask

  task automatic take();
    out_ready = 1'b1; step(); out_ready = 1'b0;
`ifdef DES_DEC_CBC_EN
    m_chain = m_ct;
`endif
  endtask

  task automatic do_block(input logic [63:0] ct, input logic [63:0] key, input int dly,
                          output logic [63:0] pt, output int lat, output logic ok);
    send(ct, key, ok);
    wait_out(lat);
    pt = out_data;
    repeat (dly) step();
    take();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 64'd0) begin bad++; $display("FAIL rst_out_data got=%h want=0", out_data); end
    rst_n = 1'b1; step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_kat(input string tag);
    logic [63:0] pt, exp; int lat; logic ok;
    exp = 64'h0123456789ABCDEF ^ cm();
    do_block(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 0, pt, lat, ok);
    total++; if (!ok || pt !== exp) begin bad++; $display("FAIL %s_data got=%h want=%h", tag, pt, exp); end
    total++; if (lat !== 16) begin bad++; $display("FAIL %s_latency got=%0d want=16", tag, lat); end
  endtask

  task automatic test_parity();
    logic [63:0] pt, exp; int lat; logic ok;
    exp = cm();
    do_block(64'h8CA64DE9C1B123A7, 64'h0, 1, pt, lat, ok);
    total++; if (!ok || pt !== exp) begin bad++; $display("FAIL parity_key0 got=%h want=%h", pt, exp); end
    exp = cm();
    do_block(64'h8CA64DE9C1B123A7, 64'h0101010101010101, 0, pt, lat, ok);
    total++; if (!ok || pt !== exp) begin bad++; $display("FAIL parity_key01 got=%h want=%h", pt, exp); end
  endtask

  task automatic test_random();
    logic [63:0] ct, key, pt, exp; int lat; logic ok;
    for (int i = 0; i < 8; i++) begin
      ct = rnd64(); key = rnd64();
      exp = des_dec(ct, key) ^ cm();
      do_block(ct, key, int'($urandom_range(3, 0)), pt, lat, ok);
      total++; if (!ok || pt !== exp || lat !== 16) begin
        bad++; $display("FAIL random_%0d got=%h want=%h lat=%0d", i, pt, exp, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] ct, key, exp, d0; int lat; logic ok, seen;
    ct = rnd64(); key = rnd64();
    exp = des_dec(ct, key) ^ cm();
    send(ct, key, ok);
    wait_out(lat);
    d0 = out_data;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin in_valid = 1'b1; in_data = rnd64(); in_key = rnd64(); end
      if (i == 5) in_valid = 1'b0;
      step();
      total++; if (out_data !== d0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold_%0d data=%h want=%h in_ready=%b out_valid=%b", i, out_data, d0, in_ready, out_valid);
      end
    end
    total++; if (d0 !== exp) begin bad++; $display("FAIL bp_data got=%h want=%h", d0, exp); end
    take();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    seen = 1'b0;
    repeat (20) begin step(); if (out_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL bp_extra_output got=%b want=0", seen); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    send(rnd64(), rnd64(), ok);
    repeat (7) step();
    rst_n = 1'b0; #1;
    total++; if (out_valid !== 1'b0 || out_data !== 64'd0) begin
      bad++; $display("FAIL midrst_async out_valid=%b out_data=%h want 0/0", out_valid, out_data);
    end
    step(); step();
    rst_n = 1'b1;
`ifdef DES_DEC_CBC_EN
    m_chain = '0;
`endif
    step();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'd0) begin
      bad++; $display("FAIL midrst_after in_ready=%b out_valid=%b out_data=%h want 1/0/0", in_ready, out_valid, out_data);
    end
    test_kat("midrst_kat");
  endtask

  task automatic test_back_to_back();
    logic [63:0] q_exp [$];
    logic [63:0] q_ct [$];
    logic [63:0] e;
    int acc_cyc [4];
    int n_acc = 0, n_out = 0, cyc = 0;
    logic acc;
    in_data = rnd64(); in_key = rnd64(); in_valid = 1'b1; out_ready = 1'b1;
    while (n_out < 4 && cyc < 300) begin
      if (out_valid) begin
        e = q_exp.pop_front();
        total++; if (out_data !== e) begin bad++; $display("FAIL b2b_data_%0d got=%h want=%h", n_out, out_data, e); end
`ifdef DES_DEC_CBC_EN
        m_chain = q_ct[0];
`endif
        void'(q_ct.pop_front());
        n_out++;
      end
      acc = in_ready && in_valid;
      if (acc) begin
        q_exp.push_back(des_dec(in_data, in_key) ^ cm());
        q_ct.push_back(in_data);
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      step(); cyc++;
      if (acc) begin
        if (n_acc < 4) begin in_data = rnd64(); in_key = rnd64(); end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (n_out !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", n_out); end
    for (int i = 1; i < n_acc; i++) begin
      total++; if (acc_cyc[i] - acc_cyc[i-1] !== 18) begin
        bad++; $display("FAIL b2b_spacing_%0d got=%0d want=18", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
  endtask

`ifdef DES_DEC_CBC_EN
  task automatic test_cbc();
    logic [63:0] pt; int lat; logic ok;
    iv = 64'hFFFFFFFFFFFFFFFF; iv_load = 1'b1;
    send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, ok);
    iv_load = 1'b0;
    m_chain = iv;
    wait_out(lat);
    pt = out_data;
    take();
    total++; if (!ok || pt !== 64'hFEDCBA9876543210) begin bad++; $display("FAIL cbc_blk1 got=%h want=FEDCBA9876543210", pt); end
    do_block(64'h8CA64DE9C1B123A7, 64'h0, 0, pt, lat, ok);
    total++; if (!ok || pt !== 64'h85E813540F0AB405) begin bad++; $display("FAIL cbc_blk2 got=%h want=85E813540F0AB405", pt); end
  endtask
`endif

  initial begin
    test_reset();
    test_kat("kat");
    test_parity();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef DES_DEC_CBC_EN
    test_cbc();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
